// File: rtl/sysid_boot_checker.sv
// Boot-time integrity check of the read-only system ID slave (ID word and build timestamp),
// sharing that slave with the CPU Avalon-MM read port whenever no check is in progress.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1353072478,
    parameter int unsigned SAMPLE_DELAY       = 1,
    localparam int unsigned DATA_W            = 32,
    localparam int unsigned MCNT_W            = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              recheck,
    input  logic              cpu_address,
    input  logic              cpu_read,
    output logic              cpu_waitrequest,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_readdatavalid,
    output logic              sid_address,
    input  logic [DATA_W-1:0] sid_readdata,
    output logic              check_done,
    output logic              id_ok,
    output logic              ts_ok,
    output logic [DATA_W-1:0] id_value,
    output logic [DATA_W-1:0] ts_value,
    output logic [MCNT_W-1:0] mismatch_count
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0]  SAMPLE_CNT = CNT_W'(SAMPLE_DELAY);
    localparam logic [MCNT_W-1:0] MCNT_MAX   = '1;

    typedef enum logic [1:0] {
        RD_ID = 2'd0,
        RD_TS = 2'd1,
        IDLE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              recheck_pending;
    logic              pending_nxt;

    logic              sample;
    logic              accept;
    logic              start_check;
    logic              id_match;
    logic              ts_match;

    assign id_match = (sid_readdata == EXPECTED_ID);
    assign ts_match = (sid_readdata == EXPECTED_TIMESTAMP);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= RD_ID;
            cnt             <= '0;
            recheck_pending <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            recheck_pending <= pending_nxt;
        end
    end

    // Next-state logic; a CPU read always wins over starting a check
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pending_nxt = recheck_pending;
        case (state)
            RD_ID: begin
                if (sample) begin
                    state_nxt = RD_TS;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = CNT_W'(cnt + 1'b1);
                end
            end
            RD_TS: begin
                if (sample) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = CNT_W'(cnt + 1'b1);
                end
            end
            IDLE: begin
                cnt_nxt = '0;
                if (accept && recheck) begin
                    pending_nxt = 1'b1;
                end
                if (start_check) begin
                    state_nxt   = RD_ID;
                    pending_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt   = RD_ID;
                cnt_nxt     = '0;
                pending_nxt = 1'b0;
            end
        endcase
    end

    // Output / decode logic: slave mux, waitrequest and per-cycle strobes
    always_comb begin
        cpu_waitrequest = 1'b1;
        sid_address     = 1'b0;
        sample          = (cnt == SAMPLE_CNT);
        accept          = 1'b0;
        start_check     = 1'b0;
        case (state)
            RD_ID: begin
                sid_address = 1'b0;
            end
            RD_TS: begin
                sid_address = 1'b1;
            end
            IDLE: begin
                cpu_waitrequest = 1'b0;
                sid_address     = cpu_address;
                accept          = cpu_read;
                start_check     = !cpu_read && (recheck || recheck_pending);
            end
            default: begin
                cpu_waitrequest = 1'b1;
            end
        endcase
    end

    // CPU read return path
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cpu_readdata      <= '0;
            cpu_readdatavalid <= 1'b0;
        end else begin
            cpu_readdatavalid <= accept;
            if (accept) begin
                cpu_readdata <= sid_readdata;
            end
        end
    end

    // Captured words survive a recheck until they are overwritten
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_value <= '0;
            ts_value <= '0;
        end else begin
            if (state == RD_ID && sample) begin
                id_value <= sid_readdata;
            end
            if (state == RD_TS && sample) begin
                ts_value <= sid_readdata;
            end
        end
    end

    // Check status flags and saturating failure counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            check_done     <= 1'b0;
            id_ok          <= 1'b0;
            ts_ok          <= 1'b0;
            mismatch_count <= '0;
        end else begin
            if (state == RD_ID && sample) begin
                id_ok <= id_match;
            end
            if (state == RD_TS && sample) begin
                ts_ok      <= ts_match;
                check_done <= 1'b1;
                if ((!id_ok || !ts_match) && mismatch_count != MCNT_MAX) begin
                    mismatch_count <= MCNT_W'(mismatch_count + 1'b1);
                end
            end
            if (start_check) begin
                check_done <= 1'b0;
                id_ok      <= 1'b0;
                ts_ok      <= 1'b0;
            end
        end
    end

endmodule
